alu16_seq: RTL and testbench
============================

// Module: alu16_seq
// PURPOSE
//  Sequences the 8-bit ALU to perform 16-bit register-pair arithmetic for the SM83 core:
//  ADD HL,rr / INC rr / DEC rr / ADD SP,e8. Each op takes two ALU passes: low byte first,
//  then high byte with the latched carry. Sits between the CPU control unit (valid/ready
//  request and response) and the shared 8-bit ALU, which it drives over an alu_* port group.
// PARAMETERS
//  none (all widths fixed by the SM83 ISA)
// PORTS
//  clk          in   1   single clock domain
//  rst_n        in   1   reset, asynchronous, active-low
//  req_valid    in   1   request present
//  req_ready    out  1   high only in IDLE
//  req_op       in   2   00 ADD16, 01 INC16, 10 DEC16, 11 ADDSP
//  req_lhs      in   16  first operand (HL, rr or SP)
//  req_rhs      in   16  ADD16: rr; ADDSP: [7:0]=e8, signed; ignored for INC16/DEC16
//  req_flags    in   4   current {Z,N,H,C}
//  resp_valid   out  1   result available; held until resp_ready
//  resp_ready   in   1   consumer accepts the result
//  resp_r       out  16  result
//  resp_flags   out  4   new {Z,N,H,C}
//  alu_lhs      out  8   ALU operand a
//  alu_rhs      out  8   ALU operand b
//  alu_op       out  4   ALU opcode (0000 ADD, 0001 ADC, 0010 SUB, 0011 SBC)
//  alu_flags    out  4   ALU {zf,nf,hf,cf}_in; only cf is significant
//  alu_r        in   8   ALU result (combinational from alu_* outputs)
//  alu_fl       in   4   ALU {zf,nf,hf,cf}_out
// BEHAVIOUR
//  - FSM: IDLE -> LO -> HI -> DONE -> IDLE. Accept on req_valid&&req_ready and latch all req_*.
//  - LO: alu_lhs=lhs[7:0]. ADD16/ADDSP: ADD with rhs[7:0]. INC16: ADD with 8'h01.
//    DEC16: SUB with 8'h01. Register alu_r, alu_fl.H and alu_fl.C as lo_h and lo_c.
//  - HI: alu_lhs=lhs[15:8], alu_flags.cf=lo_c. ADD16: ADC with rhs[15:8]. INC16: ADC with 00.
//    DEC16: SBC with 00. ADDSP: ADC with {8{rhs[7]}} (sign extension).
//    Register alu_r as high result, plus hi_h and hi_c.
//  - DONE: resp_valid=1 and resp_r/resp_flags stable until resp_ready=1, then IDLE.
//  - Latency: resp_valid rises 3 clk after the accept edge. Max throughput 1 op / 4 clk.
//  - Flags: ADD16 -> {Z_in,0,hi_h,hi_c}. INC16/DEC16 -> req_flags unchanged.
//    ADDSP -> {0,0,lo_h,lo_c} (flags come from the low byte only).
//  - Arithmetic wraps modulo 2^16 (FFFF+1=0000, 0000-1=FFFF).
//  - In IDLE/DONE, alu_lhs, alu_rhs, alu_op and alu_flags are all 0.
//  - Reset (any state, mid-op included): state=IDLE, req_ready=1, resp_valid=0,
//    resp_r=0, resp_flags=0, alu_* outputs=0, internal latches cleared.
//    Any in-flight op is dropped.
//  - req_valid outside IDLE is ignored (req_ready=0). resp_ready outside DONE is ignored.
// CONFIGURATION
//  ALU16_SEQ_SPREL_EN defined: ADDSP is implemented as above.
//  Not defined: ADDSP is accepted with the same latency and handshake, but is a no-op:
//  resp_r=req_lhs, resp_flags=req_flags, and the ALU stays idle (all alu_* = 0).
// STRUCTURE
//  Shared package alu_pkg:
//   - ALU opcode localparams (ALU_ADD..ALU_SRL)
//   - alu16 op codes (OP16_ADD, OP16_INC, OP16_DEC, OP16_ADDSP)
//   - flag bit indices (FL_Z=3, FL_N=2, FL_H=1, FL_C=0)
//   - FSM state encoding
//  One sub-module: alu16_flag_merge (combinational; op, req_flags, lo_h/lo_c, hi_h/hi_c
//  -> resp_flags). Everything else stays in alu16_seq. The ALU is instantiated by the
//  parent, not inside this block.
// TESTING
//  Bench pairs alu16_seq with the real ALU and a golden model.
//  1. ADD16 lhs=0FFF rhs=0001 flags=1000 -> r=1000 flags=1010
//     (Z kept, H=1, C=0); resp_valid 3 clk after accept.
//  2. ADD16 lhs=FFFF rhs=0001 flags=0001 -> r=0000 flags=0011.
//  3. INC16 lhs=FFFF flags=0101 -> r=0000 flags=0101. DEC16 lhs=0000 -> r=FFFF, flags unchanged.
//  4. ADDSP lhs=FFF8 e8=08 -> r=0000 flags=0011. ADDSP lhs=0005 e8=FE -> r=0003 flags=0011.
//     Without the macro: r=lhs, flags=req_flags.
//  5. Backpressure: resp_ready=0 for 5 clk -> resp_valid, resp_r and resp_flags held stable;
//     req_ready=0 throughout; a new request issued then is not accepted.
//  6. rst_n low during HI -> outputs 0 immediately, req_ready=1 after release;
//     no resp_valid for the aborted op.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: 8-bit ALU opcodes, 16-bit sequencer op codes, flag bit positions, FSM states.
// Pure declarations, no latency or handshake of its own.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_ADC  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_SBC  = 4'h3;
  localparam logic [3:0] ALU_AND  = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_CP   = 4'h7;
  localparam logic [3:0] ALU_RLC  = 4'h8;
  localparam logic [3:0] ALU_RRC  = 4'h9;
  localparam logic [3:0] ALU_RL   = 4'hA;
  localparam logic [3:0] ALU_RR   = 4'hB;
  localparam logic [3:0] ALU_SLA  = 4'hC;
  localparam logic [3:0] ALU_SRA  = 4'hD;
  localparam logic [3:0] ALU_SWAP = 4'hE;
  localparam logic [3:0] ALU_SRL  = 4'hF;

  localparam logic [1:0] OP16_ADD   = 2'b00;
  localparam logic [1:0] OP16_INC   = 2'b01;
  localparam logic [1:0] OP16_DEC   = 2'b10;
  localparam logic [1:0] OP16_ADDSP = 2'b11;

  localparam int FL_Z = 3;
  localparam int FL_N = 2;
  localparam int FL_H = 1;
  localparam int FL_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu16_seq_if.sv
// Request/response and shared-ALU signal bundle of the 16-bit sequencer; slave = sequencer side.
// Carries valid/ready handshakes only, adds no latency.
interface alu16_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_lhs;
  logic [15:0] req_rhs;
  logic [3:0]  req_flags;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_r;
  logic [3:0]  resp_flags;
  logic [7:0]  alu_lhs;
  logic [7:0]  alu_rhs;
  logic [3:0]  alu_op;
  logic [3:0]  alu_flags;
  logic [7:0]  alu_r;
  logic [3:0]  alu_fl;

  modport slave (
    input  req_valid, req_op, req_lhs, req_rhs, req_flags, resp_ready, alu_r, alu_fl,
    output req_ready, resp_valid, resp_r, resp_flags, alu_lhs, alu_rhs, alu_op, alu_flags
  );

  modport master (
    output req_valid, req_op, req_lhs, req_rhs, req_flags, resp_ready, alu_r, alu_fl,
    input  req_ready, resp_valid, resp_r, resp_flags, alu_lhs, alu_rhs, alu_op, alu_flags
  );
endinterface

// File: rtl/alu16_seq_flag_merge.sv
// Combinational result-flag selection for the 16-bit ops; zero latency, no handshake.
// ADD SP,e8 flags come from the low byte only when ALU16_SEQ_SPREL_EN is defined.
module alu16_flag_merge
  import alu_pkg::*;
(
  input  logic [1:0] i_op,
  input  logic [3:0] i_req_flags,
  input  logic       i_lo_h,
  input  logic       i_lo_c,
  input  logic       i_hi_h,
  input  logic       i_hi_c,
  output logic [3:0] o_flags
);

  always_comb begin
    o_flags = i_req_flags;
    case (i_op)
      OP16_ADD:   o_flags = {i_req_flags[FL_Z], 1'b0, i_hi_h, i_hi_c};
`ifdef ALU16_SEQ_SPREL_EN
      OP16_ADDSP: o_flags = {2'b00, i_lo_h, i_lo_c};
`endif
      default:    o_flags = i_req_flags;
    endcase
  end

`ifndef ALU16_SEQ_SPREL_EN
  logic w_unused_lo;
  assign w_unused_lo = i_lo_h ^ i_lo_c;
`endif

endmodule

// File: rtl/alu16_seq.sv
// 16-bit pair arithmetic as two passes of the shared 8-bit ALU; response handshake completes 3 clk after accept.
// resp held until resp_ready, req_ready only in IDLE; ALU16_SEQ_SPREL_EN enables ADD SP,e8 (otherwise a no-op).
module alu16_seq
  import alu_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  alu16_seq_if.slave bus
);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_op;
  logic [15:0] r_lhs;
  logic [15:0] r_rhs;
  logic [3:0]  r_flags;
  logic [7:0]  r_lo_r;
  logic [7:0]  r_hi_r;
  logic        r_lo_h;
  logic        r_lo_c;
  logic        r_hi_h;
  logic        r_hi_c;
  logic        w_accept;
  logic        w_alu_en;
  logic [3:0]  w_flags;
  logic        w_unused_fl;

  assign w_accept    = (r_state == ST_IDLE) && bus.req_valid;
  assign w_unused_fl = ^bus.alu_fl[FL_Z:FL_N];

`ifdef ALU16_SEQ_SPREL_EN
  assign w_alu_en = 1'b1;
`else
  assign w_alu_en = (r_op != OP16_ADDSP);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_LO;
      ST_LO:   w_next = ST_HI;
      ST_HI:   w_next = ST_DONE;
      ST_DONE: if (bus.resp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_lhs   <= '0;
      r_rhs   <= '0;
      r_flags <= '0;
      r_lo_r  <= '0;
      r_hi_r  <= '0;
      r_lo_h  <= 1'b0;
      r_lo_c  <= 1'b0;
      r_hi_h  <= 1'b0;
      r_hi_c  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= bus.req_op;
        r_lhs   <= bus.req_lhs;
        r_rhs   <= bus.req_rhs;
        r_flags <= bus.req_flags;
      end
      if (r_state == ST_LO && w_alu_en) begin
        r_lo_r <= bus.alu_r;
        r_lo_h <= bus.alu_fl[FL_H];
        r_lo_c <= bus.alu_fl[FL_C];
      end
      if (r_state == ST_HI && w_alu_en) begin
        r_hi_r <= bus.alu_r;
        r_hi_h <= bus.alu_fl[FL_H];
        r_hi_c <= bus.alu_fl[FL_C];
      end
    end
  end

  alu16_flag_merge u_flag_merge (
    .i_op        (r_op),
    .i_req_flags (r_flags),
    .i_lo_h      (r_lo_h),
    .i_lo_c      (r_lo_c),
    .i_hi_h      (r_hi_h),
    .i_hi_c      (r_hi_c),
    .o_flags     (w_flags)
  );

  always_comb begin
    bus.req_ready  = (r_state == ST_IDLE);
    bus.resp_valid = 1'b0;
    bus.resp_r     = '0;
    bus.resp_flags = '0;
    bus.alu_lhs    = '0;
    bus.alu_rhs    = '0;
    bus.alu_op     = ALU_ADD;
    bus.alu_flags  = '0;
    case (r_state)
      ST_LO: if (w_alu_en) begin
        bus.alu_lhs = r_lhs[7:0];
        case (r_op)
          OP16_INC: bus.alu_rhs = 8'h01;
          OP16_DEC: begin
            bus.alu_rhs = 8'h01;
            bus.alu_op  = ALU_SUB;
          end
          default:  bus.alu_rhs = r_rhs[7:0];
        endcase
      end
      // High pass consumes the low-byte carry/borrow through cf.
      ST_HI: if (w_alu_en) begin
        bus.alu_lhs        = r_lhs[15:8];
        bus.alu_flags[FL_C] = r_lo_c;
        bus.alu_op         = ALU_ADC;
        case (r_op)
          OP16_ADD:   bus.alu_rhs = r_rhs[15:8];
          OP16_ADDSP: bus.alu_rhs = {8{r_rhs[7]}};
          OP16_DEC:   bus.alu_op  = ALU_SBC;
          default:    bus.alu_rhs = 8'h00;
        endcase
      end
      ST_DONE: begin
        bus.resp_valid = 1'b1;
        bus.resp_r     = w_alu_en ? {r_hi_r, r_lo_r} : r_lhs;
        bus.resp_flags = w_flags;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq: behavioural 8-bit ALU, directed vector table, random ops against an arithmetic model,
// plus backpressure and mid-op reset sequences.
module tb_alu16_seq;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  alu16_seq_if bus();

  alu16_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared 8-bit ALU: flags {Z,N,H,C}, H/C are carry (add) or borrow (sub) out of bits 3/7.
  logic [8:0] alu_s;
  logic [4:0] alu_h;
  logic       alu_cin;
  always_comb begin
    alu_s      = '0;
    alu_h      = '0;
    alu_cin    = (bus.alu_op == ALU_ADC || bus.alu_op == ALU_SBC) ? bus.alu_flags[0] : 1'b0;
    bus.alu_r  = '0;
    bus.alu_fl = '0;
    if (bus.alu_op == ALU_ADD || bus.alu_op == ALU_ADC) begin
      alu_s      = {1'b0, bus.alu_lhs} + {1'b0, bus.alu_rhs} + {8'b0, alu_cin};
      alu_h      = {1'b0, bus.alu_lhs[3:0]} + {1'b0, bus.alu_rhs[3:0]} + {4'b0, alu_cin};
      bus.alu_r  = alu_s[7:0];
      bus.alu_fl = {alu_s[7:0] == 8'h00, 1'b0, alu_h[4], alu_s[8]};
    end else if (bus.alu_op == ALU_SUB || bus.alu_op == ALU_SBC) begin
      alu_s      = {1'b0, bus.alu_lhs} - {1'b0, bus.alu_rhs} - {8'b0, alu_cin};
      alu_h      = {1'b0, bus.alu_lhs[3:0]} - {1'b0, bus.alu_rhs[3:0]} - {4'b0, alu_cin};
      bus.alu_r  = alu_s[7:0];
      bus.alu_fl = {alu_s[7:0] == 8'h00, 1'b1, alu_h[4], alu_s[8]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: whole 16-bit arithmetic with integers, result and flags in one word {r, flags}.
  function automatic logic [19:0] model(input logic [1:0] op, input logic [15:0] lhs,
                                        input logic [15:0] rhs, input logic [3:0] fl);
    int a;
    int b;
    int e;
    logic [15:0] r;
    logic [3:0]  f;
    a = int'(lhs);
    b = int'(rhs);
    r = lhs;
    f = fl;
    case (op)
      OP16_ADD: begin
        r = 16'(a + b);
        f = {fl[3], 1'b0, ((a % 4096) + (b % 4096)) > 4095, (a + b) > 65535};
      end
      OP16_INC: r = 16'(a + 1);
      OP16_DEC: r = 16'(a - 1);
      default: begin
`ifdef ALU16_SEQ_SPREL_EN
        e = b % 256;
        r = 16'(a + ((e > 127) ? e - 256 : e));
        f = {2'b00, ((a % 16) + (e % 16)) > 15, ((a % 256) + e) > 255};
`else
        e = 0;
`endif
      end
    endcase
    return {r, f};
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [15:0] lhs, input logic [15:0] rhs,
                       input logic [3:0] fl, input int hold, output logic [15:0] r,
                       output logic [3:0] f, output int lat, output logic [23:0] alu_done,
                       output bit ok);
    int n;
    ok = 1'b1; lat = 0; r = '0; f = '0; alu_done = '0;
    bus.req_op = op; bus.req_lhs = lhs; bus.req_rhs = rhs; bus.req_flags = fl;
    bus.req_valid = 1'b1;
    bus.resp_ready = (hold == 0);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!bus.resp_valid) begin
      ok = 1'b0;
      return;
    end
    r = bus.resp_r;
    f = bus.resp_flags;
    alu_done = {bus.alu_lhs, bus.alu_rhs, bus.alu_op, bus.alu_flags};
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      bus.resp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] lhs;
    logic [15:0] rhs;
    logic [3:0]  fl;
    logic [15:0] exp_r;
    logic [3:0]  exp_f;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic [3:0]  f;
    logic [19:0] m;
    logic [23:0] ad;
    logic [15:0] held_r;
    logic [3:0]  held_f;
    int          lat;
    int          seen;
    bit          ok;

    n_cmp = 0;
    n_bad = 0;

    vecs[0] = '{OP16_ADD,   16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010};
    vecs[1] = '{OP16_ADD,   16'hFFFF, 16'h0001, 4'b0001, 16'h0000, 4'b0011};
    vecs[2] = '{OP16_INC,   16'hFFFF, 16'h0000, 4'b0101, 16'h0000, 4'b0101};
    vecs[3] = '{OP16_DEC,   16'h0000, 16'h0000, 4'b1010, 16'hFFFF, 4'b1010};
    vecs[4] = '{OP16_ADD,   16'h1234, 16'h0F0F, 4'b0000, 16'h2143, 4'b0010};
`ifdef ALU16_SEQ_SPREL_EN
    vecs[5] = '{OP16_ADDSP, 16'hFFF8, 16'h0008, 4'b1100, 16'h0000, 4'b0011};
    vecs[6] = '{OP16_ADDSP, 16'h0005, 16'h00FE, 4'b0100, 16'h0003, 4'b0011};
`else
    vecs[5] = '{OP16_ADDSP, 16'hFFF8, 16'h0008, 4'b1100, 16'hFFF8, 4'b1100};
    vecs[6] = '{OP16_ADDSP, 16'h0005, 16'h00FE, 4'b0100, 16'h0005, 4'b0100};
`endif

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_lhs = '0; bus.req_rhs = '0;
    bus.req_flags = '0; bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("reset resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("reset resp", {12'b0, bus.resp_r, bus.resp_flags}, 32'd0);
    chk("reset alu", {8'b0, bus.alu_lhs, bus.alu_rhs, bus.alu_op, bus.alu_flags}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].op, vecs[i].lhs, vecs[i].rhs, vecs[i].fl, 0, r, f, lat, ad, ok);
      chk($sformatf("vec%0d handshake", i), {31'b0, ok}, 32'd1);
      chk($sformatf("vec%0d r", i), {16'b0, r}, {16'b0, vecs[i].exp_r});
      chk($sformatf("vec%0d flags", i), {28'b0, f}, {28'b0, vecs[i].exp_f});
      chk($sformatf("vec%0d latency", i), lat, 32'd3);
      chk($sformatf("vec%0d alu idle in done", i), {8'b0, ad}, 32'd0);
    end

    for (int i = 0; i < 200; i++) begin
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  fl;
      int          hold;
      op   = 2'($urandom_range(0, 3));
      a    = 16'($urandom);
      b    = 16'($urandom);
      fl   = 4'($urandom);
      hold = $urandom_range(0, 2);
      if (i % 8 == 0) a = (i % 16 == 0) ? 16'hFFFF : 16'h0000;
      m = model(op, a, b, fl);
      do_op(op, a, b, fl, hold, r, f, lat, ad, ok);
      chk($sformatf("rand%0d op%0d handshake", i, op), {31'b0, ok}, 32'd1);
      chk($sformatf("rand%0d op%0d result", i, op), {12'b0, r, f}, {12'b0, m});
      chk($sformatf("rand%0d latency", i), lat, 32'd3);
    end

    // Backpressure: response held for 5 clk while a competing request is refused.
    m = model(OP16_ADD, 16'h0FFF, 16'h0001, 4'b1000);
    bus.req_op = OP16_ADD; bus.req_lhs = 16'h0FFF; bus.req_rhs = 16'h0001;
    bus.req_flags = 4'b1000; bus.req_valid = 1'b1; bus.resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    seen = 0;
    while (!bus.resp_valid && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    chk("bp resp_valid rises", {31'b0, bus.resp_valid}, 32'd1);
    bus.req_op = OP16_INC; bus.req_lhs = 16'h1234; bus.req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      held_r = bus.resp_r;
      held_f = bus.resp_flags;
      chk($sformatf("bp%0d resp_valid", k), {31'b0, bus.resp_valid}, 32'd1);
      chk($sformatf("bp%0d resp", k), {12'b0, held_r, held_f}, {12'b0, m});
      chk($sformatf("bp%0d req_ready", k), {31'b0, bus.req_ready}, 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b1;
    chk("bp back to idle", {31'b0, bus.req_ready}, 32'd1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid || !bus.req_ready) seen++;
    end
    chk("bp refused request never ran", seen, 32'd0);
    bus.resp_ready = 1'b0;

    // Reset asserted while the high byte is on the ALU.
    bus.req_op = OP16_ADD; bus.req_lhs = 16'h1234; bus.req_rhs = 16'h0F0F;
    bus.req_flags = 4'b1111; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("lo pass alu", {8'b0, bus.alu_lhs, bus.alu_rhs, bus.alu_op, bus.alu_flags},
        {8'b0, 8'h34, 8'h0F, ALU_ADD, 4'h0});
    @(posedge clk);
    @(negedge clk);
    chk("hi pass alu", {8'b0, bus.alu_lhs, bus.alu_rhs, bus.alu_op, bus.alu_flags},
        {8'b0, 8'h12, 8'h0F, ALU_ADC, 4'h0});
    #1 rst_n = 1'b0;
    #1;
    chk("midrst alu", {8'b0, bus.alu_lhs, bus.alu_rhs, bus.alu_op, bus.alu_flags}, 32'd0);
    chk("midrst handshake", {30'b0, bus.req_ready, bus.resp_valid}, 32'd2);
    chk("midrst resp", {12'b0, bus.resp_r, bus.resp_flags}, 32'd0);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid || !bus.req_ready) seen++;
    end
    chk("midrst aborted op dropped", seen, 32'd0);

    m = model(OP16_DEC, 16'h8000, 16'h0000, 4'b0110);
    do_op(OP16_DEC, 16'h8000, 16'h0000, 4'b0110, 0, r, f, lat, ad, ok);
    chk("post-reset op", {11'b0, ok, r, f}, {11'b0, 1'b1, m});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
